// File: rtl/sel_capture_stage.sv
// Registered capture stage for the priority-select result, with a 2-entry skid buffer on a valid/ready output.
// Define SEL_CAPTURE_STATS_EN to build the saturating per-branch delivery counters; otherwise they read 0.
module sel_capture_stage #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             d1,
   input  logic             d2,
   input  logic             cr1,
   input  logic             cr2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             tmp_q,
   output logic             tt_q,
   output logic [1:0]       src_q,
   output logic [CNT_W-1:0] cnt_cr1,
   output logic [CNT_W-1:0] cnt_cr2,
   output logic [CNT_W-1:0] cnt_dflt
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   // Entry layout: {tmp, tt, src[1:0]}
   function automatic logic [3:0] entry_f(input logic a1, input logic a2,
                                          input logic c1, input logic c2);
      logic       tmp_v;
      logic [1:0] src_v;
      if (c1) begin
         tmp_v = a1;
         src_v = 2'b01;
      end else if (c2) begin
         tmp_v = a1;
         src_v = 2'b10;
      end else begin
         tmp_v = a2;
         src_v = 2'b00;
      end
      return {tmp_v, a1 & a2, src_v};
   endfunction

   state_t     state_q, state_d;
   logic [3:0] main_q, main_d;
   logic [3:0] skid_q, skid_d;
   logic       in_ready_q, in_ready_d;
   logic       out_valid_q, out_valid_d;
   logic       accept_s;
   logic       pop_s;
   logic [3:0] new_entry_s;

   assign accept_s    = in_valid & in_ready_q;
   assign pop_s       = out_valid_q & out_ready;
   assign new_entry_s = entry_f(d1, d2, cr1, cr2);

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
         ST_EMPTY: begin
            if (accept_s) begin
               main_d  = new_entry_s;
               state_d = ST_ONE;
            end else begin
               state_d = ST_EMPTY;
            end
         end
         ST_ONE: begin
            if (accept_s && pop_s) begin
               main_d = new_entry_s;
            end else if (accept_s) begin
               skid_d  = new_entry_s;
               state_d = ST_FULL;
            end else if (pop_s) begin
               state_d = ST_EMPTY;
            end else begin
               state_d = ST_ONE;
            end
         end
         ST_FULL: begin
            if (pop_s) begin
               main_d  = skid_q;
               state_d = ST_ONE;
            end else begin
               state_d = ST_FULL;
            end
         end
         default: begin
            state_d = ST_EMPTY;
         end
      endcase
      // Handshake flags are flopped from the next state so they come straight off registers.
      in_ready_d  = (state_d != ST_FULL);
      out_valid_d = (state_d != ST_EMPTY);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_EMPTY;
         main_q      <= 4'b0000;
         skid_q      <= 4'b0000;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         main_q      <= main_d;
         skid_q      <= skid_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign tmp_q     = main_q[3];
   assign tt_q      = main_q[2];
   assign src_q     = main_q[1:0];

`ifdef SEL_CAPTURE_STATS_EN
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] cnt_cr1_q, cnt_cr1_d;
   logic [CNT_W-1:0] cnt_cr2_q, cnt_cr2_d;
   logic [CNT_W-1:0] cnt_dflt_q, cnt_dflt_d;

   function automatic logic [CNT_W-1:0] sat_inc_f(input logic [CNT_W-1:0] v);
      if (v == CNT_MAX) begin
         return v;
      end else begin
         return v + CNT_ONE;
      end
   endfunction

   always_comb begin
      cnt_cr1_d  = cnt_cr1_q;
      cnt_cr2_d  = cnt_cr2_q;
      cnt_dflt_d = cnt_dflt_q;
      if (pop_s) begin
         case (src_q)
            2'b01:   cnt_cr1_d  = sat_inc_f(cnt_cr1_q);
            2'b10:   cnt_cr2_d  = sat_inc_f(cnt_cr2_q);
            2'b00:   cnt_dflt_d = sat_inc_f(cnt_dflt_q);
            default: cnt_dflt_d = cnt_dflt_q;
         endcase
      end else begin
         cnt_dflt_d = cnt_dflt_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_cr1_q  <= {CNT_W{1'b0}};
         cnt_cr2_q  <= {CNT_W{1'b0}};
         cnt_dflt_q <= {CNT_W{1'b0}};
      end else begin
         cnt_cr1_q  <= cnt_cr1_d;
         cnt_cr2_q  <= cnt_cr2_d;
         cnt_dflt_q <= cnt_dflt_d;
      end
   end

   assign cnt_cr1  = cnt_cr1_q;
   assign cnt_cr2  = cnt_cr2_q;
   assign cnt_dflt = cnt_dflt_q;
`else
   assign cnt_cr1  = {CNT_W{1'b0}};
   assign cnt_cr2  = {CNT_W{1'b0}};
   assign cnt_dflt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_sel_capture_stage.sv
// Directed bench for sel_capture_stage with a queue scoreboard and an occupancy/counter model.
module tb_sel_capture_stage;

   localparam int CNT_W = 2;
`ifdef SEL_CAPTURE_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic             d1 = 1'b0, d2 = 1'b0, cr1 = 1'b0, cr2 = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic             tmp_q, tt_q;
   logic [1:0]       src_q;
   logic [CNT_W-1:0] cnt_cr1, cnt_cr2, cnt_dflt;

   int checks = 0;
   int failures = 0;
   logic [3:0] sb_q[$];
   logic [CNT_W-1:0] m_cr1 = '0, m_cr2 = '0, m_dflt = '0;
   bit acc_last;
   int n_pop = 0;

   sel_capture_stage #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .d1(d1), .d2(d2), .cr1(cr1), .cr2(cr2),
      .out_valid(out_valid), .out_ready(out_ready),
      .tmp_q(tmp_q), .tt_q(tt_q), .src_q(src_q),
      .cnt_cr1(cnt_cr1), .cnt_cr2(cnt_cr2), .cnt_dflt(cnt_dflt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] model_f(input logic a1, a2, c1, c2);
      logic       t;
      logic [1:0] s;
      t = c1 ? a1 : (c2 ? a1 : a2);
      s = c1 ? 2'b01 : (c2 ? 2'b10 : 2'b00);
      return {t, a1 & a2, s};
   endfunction

   function automatic logic [CNT_W-1:0] sat_f(input logic [CNT_W-1:0] v);
      return (STATS && v != {CNT_W{1'b1}}) ? v + 1'b1 : v;
   endfunction

   // One cycle: drive at negedge, check against the model, update the model, advance.
   task automatic step(input logic r, iv, a1, a2, c1, c2, ordy);
      logic pop_m, acc_m;
      rst = r; in_valid = iv; d1 = a1; d2 = a2; cr1 = c1; cr2 = c2; out_ready = ordy;
      #1;
      chk("out_valid", {7'd0, out_valid}, {7'd0, sb_q.size() > 0});
      chk("in_ready",  {7'd0, in_ready},  {7'd0, sb_q.size() < 2});
      chk("cnt_cr1",  8'(cnt_cr1),  8'(m_cr1));
      chk("cnt_cr2",  8'(cnt_cr2),  8'(m_cr2));
      chk("cnt_dflt", 8'(cnt_dflt), 8'(m_dflt));
      if (sb_q.size() > 0) begin
         chk("head_entry", {4'd0, tmp_q, tt_q, src_q}, {4'd0, sb_q[0]});
      end
      pop_m = (sb_q.size() > 0) && ordy;
      acc_m = iv && (sb_q.size() < 2);
      acc_last = 1'b0;
      if (r) begin
         sb_q.delete();
         m_cr1 = '0; m_cr2 = '0; m_dflt = '0;
      end else begin
         if (pop_m) begin
            case (sb_q[0][1:0])
               2'b01:   m_cr1 = sat_f(m_cr1);
               2'b10:   m_cr2 = sat_f(m_cr2);
               default: m_dflt = sat_f(m_dflt);
            endcase
            void'(sb_q.pop_front());
            n_pop++;
         end
         if (acc_m) begin
            sb_q.push_back(model_f(a1, a2, c1, c2));
            acc_last = 1'b1;
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   logic [3:0] ents [4];
   int idx;
   int pop_base;

   initial begin
      ents[0] = 4'b1001; ents[1] = 4'b0110; ents[2] = 4'b1100; ents[3] = 4'b0011;
      @(negedge clk);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("rst_tmp", {7'd0, tmp_q}, 8'd0);
      chk("rst_tt",  {7'd0, tt_q},  8'd0);
      chk("rst_src", {6'd0, src_q}, 8'd0);

      // single accept, then pop, then empty
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      chk("t1_src", {6'd0, src_q}, 8'h01);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

      // priority: cr2 only, none, both
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
      chk("prio_cr2", {5'd0, tmp_q, src_q}, 8'b0000_0010);
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      chk("prio_dflt", {5'd0, tmp_q, src_q}, 8'b0000_0100);
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
      chk("prio_both", {6'd0, src_q}, 8'h01);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

      // backpressure: upstream holds each sample until accepted
      idx = 0;
      pop_base = n_pop;
      for (int k = 0; k < 4; k++) begin
         step(1'b0, 1'b1, ents[idx][3], ents[idx][2], ents[idx][1], ents[idx][0], 1'b0);
         if (acc_last) idx++;
      end
      chk("bp_accepted", 8'(idx), 8'd2);
      for (int k = 0; k < 16 && !(idx == 4 && sb_q.size() == 0); k++) begin
         step(1'b0, idx < 4, ents[idx % 4][3], ents[idx % 4][2], ents[idx % 4][1], ents[idx % 4][0], 1'b1);
         if (acc_last) idx++;
      end
      chk("bp_all_in", 8'(idx), 8'd4);
      chk("bp_all_out", 8'(n_pop - pop_base), 8'd4);

      // reset while full, with a concurrent pop and offered input
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("full_in_ready", {7'd0, in_ready}, 8'd0);
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("rstfull_out_valid", {7'd0, out_valid}, 8'd0);
      chk("rstfull_in_ready",  {7'd0, in_ready},  8'd1);
      chk("rstfull_cnt", 8'(cnt_cr1 | cnt_cr2 | cnt_dflt), 8'd0);

      // five default-branch pops saturate the 2-bit counter
      pop_base = n_pop;
      for (int k = 0; k < 5; k++) begin
         step(1'b0, 1'b1, k[0], k[1], 1'b0, 1'b0, 1'b1);
      end
      for (int k = 0; k < 4 && sb_q.size() != 0; k++) begin
         step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      end
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("sat_pops", 8'(n_pop - pop_base), 8'd5);
      chk("sat_dflt", 8'(cnt_dflt), STATS ? 8'd3 : 8'd0);
      chk("sat_cr1",  8'(cnt_cr1), 8'd0);
      chk("sat_cr2",  8'(cnt_cr2), 8'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
